// File: rtl/serial_word_rx.sv
// serial_word_rx: start/stop framed serial receiver with a one-entry valid/ready holding register.
// Optional even-parity stage is enabled by defining SERIAL_RX_PARITY_EN.
module serial_word_rx #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             bit_en,
  input  logic             dir,
  input  logic             ready,
  output logic [WIDTH-1:0] po,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
    PARITY = 2'd2,
`endif
    STOP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frameErr_q, frameErr_d;
  logic             deliver;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parBit_q, parBit_d;
  logic             parityErr_q, parityErr_d;
`endif

  // Armed must be re-established by a high sample, so a stuck-low line never starts frames.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    dir_d      = dir_q;
    armed_d    = armed_q;
    deliver    = 1'b0;
    frameErr_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d      = par_q;
    parBit_d   = parBit_q;
`endif
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (si) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = DATA;
            dir_d   = dir;
            cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end
        DATA: begin
          sreg_d = dir_q ? {sreg_q[WIDTH-2:0], si} : {si, sreg_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          par_d  = par_q ^ si;
          if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY;
`else
          if (cnt_q == CW'(WIDTH - 1)) state_d = STOP;
`endif
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          parBit_d = si;
          state_d  = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          if (si) begin
            deliver = 1'b1;
            armed_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
            armed_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register: a delivery wins over consumption when both happen in one cycle.
  always_comb begin
    po_d        = po_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    parityErr_d = parityErr_q;
`endif
    if (deliver) begin
      if (!valid_q || ready) begin
        po_d        = sreg_q;
        valid_d     = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        parityErr_d = parBit_q ^ par_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      dir_q       <= 1'b0;
      armed_q     <= 1'b0;
      po_q        <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frameErr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q       <= 1'b0;
      parBit_q    <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      dir_q       <= dir_d;
      armed_q     <= armed_d;
      po_q        <= po_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frameErr_q  <= frameErr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q       <= par_d;
      parBit_q    <= parBit_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  assign po        = po_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign frame_err = frameErr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: table of framed words plus hand sequences for
// overrun, framing error / re-arm, strobe gaps, back-to-back frames and reset.
module tb_serial_word_rx;

  localparam int W = 5;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         si = 1'b1;
  logic         bit_en = 1'b0;
  logic         dir = 1'b1;
  logic         ready = 1'b0;
  logic [W-1:0] po;
  logic         valid, busy, overrun, frame_err, parity_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         d;
    logic [W-1:0] s;
    logic         stopB;
    logic         parB;
    logic [W-1:0] expPo;
    logic         expValid;
    logic         expFe;
    logic         expPe;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .si(si), .bit_en(bit_en), .dir(dir), .ready(ready),
    .po(po), .valid(valid), .busy(busy), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b, input int gap);
    repeat (gap) begin
      bit_en = 1'b0;
      tick();
    end
    si     = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic clearValid();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Serial order is s[W-1] first; returns just after the edge that sampled the stop bit.
  task automatic applyStimulus(input logic d, input logic [W-1:0] s, input logic stopB,
                               input logic parB, input int gap, input bit withIdle,
                               input bit toggleDir);
    dir = d;
    if (withIdle) sendBit(1'b1, gap);
    sendBit(1'b0, gap);
    checkBit("busy_after_start", busy, 1'b1);
    if (toggleDir) dir = ~d;
    for (int i = 0; i < W; i++) sendBit(s[W-1-i], gap);
    if (PAR_ON) sendBit(parB, gap);
    sendBit(stopB, gap);
    dir = d;
  endtask

  initial begin
    //       d     s         stop  par   expPo     val   fe    pe
    vecs[0] = '{1'b1, 5'b10110, 1'b1, 1'b1, 5'b10110, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 5'b10110, 1'b1, 1'b0, 5'b01101, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'b00011, 1'b1, 1'b0, 5'b00011, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'b00011, 1'b1, 1'b1, 5'b11000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 5'b11111, 1'b1, 1'b1, 5'b11111, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 5'b10000, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'b01010, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 5'b01010, 1'b1, 1'b0, 5'b01010, 1'b1, 1'b0, 1'b0};

    rst    = 1'b0;
    bit_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      si = ~si;
      tick();
    end
    bit_en = 1'b0;
    si     = 1'b1;
    checkOutput("reset_po", po, 5'b00000);
    checkBit("reset_valid", valid, 1'b0);
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_overrun", overrun, 1'b0);
    checkBit("reset_frame_err", frame_err, 1'b0);
    checkBit("reset_parity_err", parity_err, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      clearValid();
      applyStimulus(vecs[i].d, vecs[i].s, vecs[i].stopB, vecs[i].parB, 0, 1'b1, 1'b0);
      checkBit("vec_valid", valid, vecs[i].expValid);
      if (vecs[i].expValid) begin
        checkOutput("vec_po", po, vecs[i].expPo);
        checkBit("vec_parity_err", parity_err, PAR_ON ? vecs[i].expPe : 1'b0);
      end
      checkBit("vec_busy", busy, 1'b0);
      checkBit("vec_frame_err", frame_err, vecs[i].expFe);
      checkBit("vec_overrun", overrun, 1'b0);
      if (vecs[i].expFe) begin
        tick();
        checkBit("vec_frame_err_pulse_end", frame_err, 1'b0);
      end
    end

    clearValid();
    applyStimulus(1'b0, 5'b10110, 1'b1, 1'b1, 0, 1'b1, 1'b1);
    checkOutput("dir_toggle_po", po, 5'b01101);
    checkBit("dir_toggle_valid", valid, 1'b1);

    clearValid();
    applyStimulus(1'b1, 5'b11001, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    checkOutput("gap_po", po, 5'b11001);
    checkBit("gap_valid", valid, 1'b1);
    checkBit("gap_parity_err", parity_err, 1'b0);

    clearValid();
    ready = 1'b1;
    applyStimulus(1'b1, 5'b11001, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    checkOutput("b2b_first_po", po, 5'b11001);
    applyStimulus(1'b1, 5'b00110, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("b2b_second_po", po, 5'b00110);
    checkBit("b2b_second_valid", valid, 1'b1);
    ready = 1'b0;

    clearValid();
    applyStimulus(1'b1, 5'b11100, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    checkBit("ferr_pulse", frame_err, 1'b1);
    checkBit("ferr_valid", valid, 1'b0);
    tick();
    checkBit("ferr_pulse_end", frame_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sendBit(1'b0, 0);
      checkBit("unarmed_busy", busy, 1'b0);
    end
    applyStimulus(1'b1, 5'b10011, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    checkOutput("rearm_po", po, 5'b10011);
    checkBit("rearm_valid", valid, 1'b1);

    clearValid();
    applyStimulus(1'b1, 5'b10110, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'b00011, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("overrun_po_held", po, 5'b10110);
    checkBit("overrun_valid", valid, 1'b1);
    checkBit("overrun_flag", overrun, 1'b1);
    clearValid();
    checkBit("overrun_consumed_valid", valid, 1'b0);
    checkBit("overrun_sticky", overrun, 1'b1);
    checkOutput("overrun_po_kept", po, 5'b10110);

    sendBit(1'b1, 0);
    sendBit(1'b0, 0);
    sendBit(1'b1, 0);
    sendBit(1'b1, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkBit("midreset_busy", busy, 1'b0);
    checkBit("midreset_valid", valid, 1'b0);
    checkOutput("midreset_po", po, 5'b00000);
    checkBit("midreset_overrun", overrun, 1'b0);
    applyStimulus(1'b0, 5'b00011, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("post_reset_po", po, 5'b11000);
    checkBit("post_reset_valid", valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
